// File: rtl/lsu_pkg.sv
// lsu_pkg: shared Funct3 codes, FSM states and access-size helpers for the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} lsu_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    return (f3 == F3_B || f3 == F3_BU) ? SZ_B : (f3 == F3_H || f3 == F3_HU) ? SZ_H : SZ_W;
  endfunction

  function automatic logic [3:0] size_mask(input lsu_size_t s);
    return s == SZ_B ? 4'b0001 : s == SZ_H ? 4'b0011 : 4'b1111;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for stores and extraction/extension for loads.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wd,
  input  logic [63:0] rdata,
  output logic [63:0] sdata,
  output logic [7:0]  smask,
  output logic [31:0] rd
);
  logic [3:0]  m;
  logic [31:0] x;
  assign m = size_mask(lsu_size_t'(size));
  assign smask = {4'b0, m} << off;
  assign sdata = {32'b0, wd & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}}} << {off, 3'b000};
  assign x = 32'(rdata >> {off, 3'b000});
  assign rd = size == SZ_B ? {{24{x[7] & ~uns}}, x[7:0]} :
              size == SZ_H ? {{16{x[15] & ~uns}}, x[15:0]} : x;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator; splits word-crossing accesses into two transactions.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of splitting them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     rd,
  output logic                  done,
  output logic                  stall,
  output logic                  misalign_exc,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  lsu_state_t state, state_nxt;
  lsu_size_t size, size_q;
  logic req, wr, mis, wr_q, uns_q, mis_q, acc, hi;
  logic [DM_ADDRESS-1:0] a_q, word0;
  logic [DATA_W-1:0] wd_q, w0, rd_q, ld_res;
  logic [63:0] sdata;
  logic [7:0] smask;
  assign req = MemRead | MemWrite;
  assign wr = MemWrite & ~MemRead;
  assign size = f3_size(Funct3);
  assign mis = (size == SZ_H && a[1:0] == 2'd3) || (size == SZ_W && a[1:0] != 2'd0);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (TRAP && mis) ? RESP : ACC1;
      ACC1:    state_nxt = mis_q ? ACC2 : RESP;
      ACC2:    state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      size_q <= SZ_B;
      wr_q   <= 1'b0;
      uns_q  <= 1'b0;
      mis_q  <= 1'b0;
      a_q    <= '0;
      wd_q   <= '0;
      w0     <= '0;
      rd_q   <= '0;
    end else begin
      state <= state_nxt;
      rd_q  <= rd;
      if (state == IDLE && req) begin
        size_q <= size;
        wr_q   <= wr;
        uns_q  <= Funct3 == F3_BU || Funct3 == F3_HU;
        mis_q  <= mis;
        a_q    <= a;
        wd_q   <= wd;
      end
      if (state == ACC2) w0 <= mem_rdata;
    end
  lsu_lane_align u_align (
    .size  (size_q),
    .off   (a_q[1:0]),
    .uns   (uns_q),
    .wd    (wd_q),
    .rdata (mis_q ? {mem_rdata, w0} : {32'b0, mem_rdata}),
    .sdata (sdata),
    .smask (smask),
    .rd    (ld_res)
  );
  // second word wraps naturally at the top of the address space
  assign word0 = {a_q[DM_ADDRESS-1:2], 2'b00};
  assign acc = state == ACC1 || state == ACC2;
  assign hi = state == ACC2;
  assign mem_addr = acc ? (hi ? word0 + DM_ADDRESS'(4) : word0) : '0;
  assign mem_re = acc & ~wr_q;
  assign mem_we = acc & wr_q;
  assign mem_be = mem_we ? (hi ? smask[7:4] : smask[3:0]) : 4'b0;
  assign mem_wdata = mem_we ? (hi ? sdata[63:32] : sdata[31:0]) : '0;
  assign done = state == RESP;
  assign stall = req & ~done;
  assign misalign_exc = TRAP & done & mis_q;
  assign rd = (done && !wr_q && !misalign_exc) ? ld_res : rd_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand sequences against a byte-enable memory.
module tb_load_store_unit;
  logic clk = 1'b0, rst_n = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, load_mem = 1'b0;
  logic [2:0] Funct3 = 3'b0;
  logic [8:0] a = '0, mem_addr;
  logic [31:0] wd = '0, rd, mem_wdata, mem_rdata;
  logic done, stall, misalign_exc, mem_re, mem_we;
  logic [3:0] mem_be;
  logic [31:0] mem [128];
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .a(a), .wd(wd), .rd(rd), .done(done), .stall(stall), .misalign_exc(misalign_exc),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk)
    if (load_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[0]   <= 32'h77665544;
      mem[3]   <= 32'h11223344;
      mem[4]   <= 32'hDEADBEEF;
      mem[8]   <= 32'h80FF7F01;
      mem[127] <= 32'h33221100;
      mem_rdata <= '0;
    end else begin
      if (mem_we)
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) mem[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic mr, mw;
    logic [2:0] f3;
    logic [8:0] a;
    logic [31:0] wd, exp_rd;
    int lat, n_re, n_we;
  } vec_t;

  task automatic run_op(input vec_t v, input int idx);
    int n = 0, re_n = 0, we_n = 0;
    MemRead = v.mr; MemWrite = v.mw; Funct3 = v.f3; a = v.a; wd = v.wd;
    #1 chk($sformatf("v%0d stall_t0", idx), 32'(stall), 32'd1);
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
      re_n += int'(mem_re);
      we_n += int'(mem_we);
    end
    chk($sformatf("v%0d latency", idx), n, v.lat);
    chk($sformatf("v%0d re_count", idx), re_n, v.n_re);
    chk($sformatf("v%0d we_count", idx), we_n, v.n_we);
    chk($sformatf("v%0d stall_done", idx), 32'(stall), 32'd0);
    chk($sformatf("v%0d exc", idx), 32'(misalign_exc), 32'd0);
    if (v.mr) chk($sformatf("v%0d rd", idx), rd, v.exp_rd);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
  endtask

  vec_t vt [26];

  initial begin
    vt[0]  = '{1, 0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 2, 1, 0};
    vt[1]  = '{1, 0, 3'b000, 9'h023, 32'h0, 32'hFFFFFF80, 2, 1, 0};
    vt[2]  = '{1, 0, 3'b100, 9'h023, 32'h0, 32'h00000080, 2, 1, 0};
    vt[3]  = '{1, 0, 3'b000, 9'h020, 32'h0, 32'h00000001, 2, 1, 0};
    vt[4]  = '{1, 0, 3'b001, 9'h021, 32'h0, 32'hFFFFFF7F, 2, 1, 0};
    vt[5]  = '{1, 0, 3'b101, 9'h021, 32'h0, 32'h0000FF7F, 2, 1, 0};
    vt[6]  = '{1, 0, 3'b001, 9'h022, 32'h0, 32'hFFFF80FF, 2, 1, 0};
    vt[7]  = '{1, 0, 3'b010, 9'h1FE, 32'h0, 32'h55443322, 3, 2, 0};
    vt[8]  = '{1, 0, 3'b001, 9'h1FF, 32'h0, 32'h00004433, 3, 2, 0};
    vt[9]  = '{1, 0, 3'b010, 9'h004, 32'h0, 32'hCD000000, 2, 1, 0};
    vt[10] = '{1, 0, 3'b010, 9'h008, 32'h0, 32'h000000AB, 2, 1, 0};
    vt[11] = '{0, 1, 3'b000, 9'h00D, 32'hFFFFFF5A, 32'h0, 2, 0, 1};
    vt[12] = '{1, 0, 3'b010, 9'h00C, 32'h0, 32'h11225A44, 2, 1, 0};
    vt[13] = '{0, 1, 3'b010, 9'h00C, 32'hCAFEF00D, 32'h0, 2, 0, 1};
    vt[14] = '{1, 0, 3'b101, 9'h00E, 32'h0, 32'h0000CAFE, 2, 1, 0};
    vt[15] = '{0, 1, 3'b100, 9'h010, 32'h12345678, 32'h0, 2, 0, 1};
    vt[16] = '{1, 0, 3'b010, 9'h010, 32'h0, 32'hDEADBE78, 2, 1, 0};
    vt[17] = '{1, 0, 3'b011, 9'h020, 32'h0, 32'h80FF7F01, 2, 1, 0};
    vt[18] = '{1, 1, 3'b010, 9'h010, 32'hFFFFFFFF, 32'hDEADBE78, 2, 1, 0};
    vt[19] = '{0, 1, 3'b010, 9'h1FD, 32'hA1B2C3D4, 32'h0, 3, 0, 2};
    vt[20] = '{1, 0, 3'b010, 9'h1FC, 32'h0, 32'hB2C3D400, 2, 1, 0};
    vt[21] = '{1, 0, 3'b010, 9'h000, 32'h0, 32'h776655A1, 2, 1, 0};
    vt[22] = '{1, 0, 3'b101, 9'h002, 32'h0, 32'h00007766, 2, 1, 0};
    vt[23] = '{0, 1, 3'b101, 9'h006, 32'hFFFF1357, 32'h0, 2, 0, 1};
    vt[24] = '{1, 0, 3'b010, 9'h004, 32'h0, 32'h13570000, 2, 1, 0};
    vt[25] = '{1, 0, 3'b001, 9'h005, 32'h0, 32'h00005700, 2, 1, 0};

    load_mem = 1'b1;
    @(negedge clk);
    load_mem = 1'b0;
    chk("rst rd", rd, 32'h0);
    chk("rst done", 32'(done), 32'h0);
    chk("rst stall", 32'(stall), 32'h0);
    chk("rst exc", 32'(misalign_exc), 32'h0);
    chk("rst strobes", {30'h0, mem_re, mem_we}, 32'h0);
    chk("rst be", 32'(mem_be), 32'h0);
    chk("rst addr", 32'(mem_addr), 32'h0);
    chk("rst wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef LSU_MISALIGN_TRAP_EN
    MemWrite = 1'b1; Funct3 = 3'b010; a = 9'h002; wd = 32'h12345678;
    #1 chk("trap stall_t0", 32'(stall), 32'd1);
    @(negedge clk);
    chk("trap done", 32'(done), 32'd1);
    chk("trap exc", 32'(misalign_exc), 32'd1);
    chk("trap strobes", {30'h0, mem_re, mem_we}, 32'h0);
    chk("trap rd", rd, 32'h0);
    MemWrite = 1'b0;
    @(negedge clk);
    chk("trap exc_pulse", 32'(misalign_exc), 32'd0);
    chk("trap mem", mem[0], 32'h77665544);
`else
    MemWrite = 1'b1; Funct3 = 3'b001; a = 9'h007; wd = 32'h0000ABCD;
    #1 chk("sh stall_t0", 32'(stall), 32'd1);
    @(negedge clk);
    chk("sh t1 we", 32'(mem_we), 32'd1);
    chk("sh t1 addr", 32'(mem_addr), 32'h004);
    chk("sh t1 be", 32'(mem_be), 32'b1000);
    chk("sh t1 wdata", mem_wdata, 32'hCD000000);
    @(negedge clk);
    chk("sh t2 we", 32'(mem_we), 32'd1);
    chk("sh t2 addr", 32'(mem_addr), 32'h008);
    chk("sh t2 be", 32'(mem_be), 32'b0001);
    chk("sh t2 wdata", mem_wdata, 32'h000000AB);
    chk("sh t2 done", 32'(done), 32'd0);
    @(negedge clk);
    chk("sh t3 done", 32'(done), 32'd1);
    MemWrite = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 26; i++) run_op(vt[i], i);

    MemWrite = 1'b1; Funct3 = 3'b001; a = 9'h007; wd = 32'h00009999;
    @(negedge clk);
    chk("rmid t1 we", 32'(mem_we), 32'd1);
    rst_n = 1'b0; MemWrite = 1'b0;
    #1;
    chk("rmid strobes", {30'h0, mem_re, mem_we}, 32'h0);
    chk("rmid be", 32'(mem_be), 32'h0);
    chk("rmid addr", 32'(mem_addr), 32'h0);
    chk("rmid rd", rd, 32'h0);
    begin
      int we_n = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        we_n += int'(mem_we);
      end
      chk("rmid late_we", we_n, 0);
    end
    run_op('{1, 0, 3'b010, 9'h004, 32'h0, 32'h13570000, 2, 1, 0}, 100);
    run_op('{1, 0, 3'b010, 9'h008, 32'h0, 32'h000000AB, 2, 1, 0}, 101);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
